// File: rtl/tile_move_controller.sv
// Game-play sequencer for the current-tile store: spawns tiles, applies legal
// player/gravity moves, detects landing and hands off to merge via a lock handshake.
package tile_move_pkg;
  typedef struct packed {
    logic [3:0] x;
    logic [4:0] y;
  } point_t;

  typedef enum logic [2:0] {
    TILE_I, TILE_O, TILE_T, TILE_S, TILE_Z, TILE_J, TILE_L
  } tile_type_e;

  typedef enum logic [2:0] {
    sSPAWN, sWAIT_SPAWN, sFETCH, sWAIT, sPLAY, sLOCK, sCLEAR, sOVER
  } state_e;
endpackage

module tile_move_controller
  import tile_move_pkg::*;
#(
  parameter logic [3:0] spawn_x_p = 4'd3,
  parameter logic [4:0] spawn_y_p = 5'd0
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       cmd_left_i,
  input  logic       cmd_right_i,
  input  logic       cmd_rotate_i,
  input  logic       cmd_down_i,
  input  logic       tick_i,
  input  logic       restart_i,
  input  logic       ready_i,
  input  point_t     pos_i,
  input  tile_type_e type_i,
  input  logic [1:0] angle_i,
  input  tile_type_e next_type_i,
  input  logic [1:0] next_angle_i,
  input  logic [3:0] move_avail_i,
  output tile_type_e tile_type_o,
  output logic [1:0] tile_angle_o,
  output logic       tile_type_v_o,
  output point_t     new_pos_o,
  output logic       pos_v_o,
  output logic       fetch_next_o,
  output logic       empty_o,
  output logic       lock_o,
  input  logic       lock_ack_i,
  output logic       game_over_o,
  output state_e     dbg_state_o
);

  // Pending-bit indices line up with the move_avail_i bit order.
  localparam int P_L   = 0;
  localparam int P_R   = 1;
  localparam int P_DN  = 2;
  localparam int P_ROT = 3;

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_pend;
  logic       r_topout;

  logic [3:0] w_set;
  logic [3:0] w_clr;
  logic [3:0] w_srv;
  logic       w_topout_ld;
  logic       w_topout_clr;
  tile_type_e w_tile_type;
  logic [1:0] w_tile_angle;
  logic       w_tile_type_v;
  point_t     w_new_pos;
  logic       w_pos_v;
  logic       w_fetch_next;
  logic       w_empty;
  logic       w_lock;
  logic       w_game_over;

  assign w_set = (r_state == sOVER) ? 4'b0000 :
                 {cmd_rotate_i, cmd_down_i | tick_i, cmd_right_i, cmd_left_i};

  // Handshake: a load strobe (tile_type_v_o / pos_v_o) is only issued while
  // ready_i is high; the store accepts it that cycle and drops ready_i the
  // next, so every strobe is exactly one cycle and is followed by a wait state.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr         = 4'b0000;
    w_srv         = 4'b0000;
    w_topout_ld   = 1'b0;
    w_topout_clr  = 1'b0;
    w_tile_type   = TILE_I;
    w_tile_angle  = 2'd0;
    w_tile_type_v = 1'b0;
    w_new_pos     = '0;
    w_pos_v       = 1'b0;
    w_fetch_next  = 1'b0;
    w_empty       = 1'b0;
    w_lock        = 1'b0;
    w_game_over   = 1'b0;

    case (r_state)
      sSPAWN: begin
        if (ready_i) begin
          w_tile_type_v = 1'b1;
          w_tile_type   = next_type_i;
          w_tile_angle  = next_angle_i;
          w_pos_v       = 1'b1;
          w_new_pos.x   = spawn_x_p;
          w_new_pos.y   = spawn_y_p;
          w_state_nxt   = sWAIT_SPAWN;
        end
      end
      sWAIT_SPAWN: if (ready_i) w_state_nxt = sFETCH;
      sFETCH: begin
        w_fetch_next = 1'b1;
        w_state_nxt  = sWAIT;
      end
      sWAIT: if (ready_i) w_state_nxt = sPLAY;
      sPLAY: begin
        if (ready_i) begin
          w_new_pos = pos_i;
          if (r_pend[P_ROT]) begin
            w_srv[P_ROT] = 1'b1;
            w_clr[P_ROT] = 1'b1;
            if (move_avail_i[P_ROT]) begin
              w_tile_type_v = 1'b1;
              w_tile_type   = type_i;
              w_tile_angle  = angle_i + 2'd1;
              w_state_nxt   = sWAIT;
            end
          end else if (r_pend[P_L]) begin
            w_srv[P_L] = 1'b1;
            w_clr[P_L] = 1'b1;
            if (move_avail_i[P_L]) begin
              w_pos_v     = 1'b1;
              w_new_pos.x = pos_i.x - 4'd1;
              w_state_nxt = sWAIT;
            end
          end else if (r_pend[P_R]) begin
            w_srv[P_R] = 1'b1;
            w_clr[P_R] = 1'b1;
            if (move_avail_i[P_R]) begin
              w_pos_v     = 1'b1;
              w_new_pos.x = pos_i.x + 4'd1;
              w_state_nxt = sWAIT;
            end
          end else if (r_pend[P_DN]) begin
            w_srv[P_DN] = 1'b1;
            if (move_avail_i[P_DN]) begin
              w_clr[P_DN] = 1'b1;
              w_pos_v     = 1'b1;
              w_new_pos.y = pos_i.y + 5'd1;
              w_state_nxt = sWAIT;
            end else begin
              // Landed: the whole queue is stale once the tile is fixed.
              w_clr       = 4'b1111;
              w_topout_ld = 1'b1;
              w_state_nxt = sLOCK;
            end
          end
          if (!w_pos_v) w_new_pos = '0;
        end
      end
      sLOCK: begin
        w_lock = 1'b1;
        if (lock_ack_i) w_state_nxt = sCLEAR;
      end
      sCLEAR: begin
        w_empty     = 1'b1;
        w_state_nxt = r_topout ? sOVER : sSPAWN;
      end
      sOVER: begin
        w_game_over = 1'b1;
        if (restart_i) begin
          w_empty      = 1'b1;
          w_topout_clr = 1'b1;
          w_state_nxt  = sSPAWN;
        end
      end
      default: w_state_nxt = sSPAWN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state  <= sSPAWN;
      r_pend   <= 4'b0000;
      r_topout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // A new pulse survives a same-cycle clear unless it hits the served bit.
      r_pend  <= (r_pend & ~w_clr) | (w_set & ~w_srv);
      if (w_topout_ld)       r_topout <= (pos_i.y == spawn_y_p);
      else if (w_topout_clr) r_topout <= 1'b0;
    end
  end

  // Outputs are decoded from state; holding them low during reset keeps
  // sSPAWN from strobing while the store is itself still in reset.
  assign tile_type_o   = reset_ni ? w_tile_type : TILE_I;
  assign tile_angle_o  = reset_ni ? w_tile_angle : 2'd0;
  assign tile_type_v_o = reset_ni & w_tile_type_v;
  assign new_pos_o     = reset_ni ? w_new_pos : '0;
  assign pos_v_o       = reset_ni & w_pos_v;
  assign fetch_next_o  = reset_ni & w_fetch_next;
  assign empty_o       = reset_ni & w_empty;
  assign lock_o        = reset_ni & w_lock;
  assign game_over_o   = reset_ni & w_game_over;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_tile_move_controller.sv
// Directed bench for tile_move_controller: spawn, moves, priority, landing,
// top-out and asynchronous reset, with hand-computed expectations.
module tb_tile_move_controller;
  import tile_move_pkg::*;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       cmd_left_i, cmd_right_i, cmd_rotate_i, cmd_down_i;
  logic       tick_i, restart_i, ready_i, lock_ack_i;
  point_t     pos_i, new_pos_o;
  tile_type_e type_i, next_type_i, tile_type_o;
  logic [1:0] angle_i, next_angle_i, tile_angle_o;
  logic [3:0] move_avail_i;
  logic       tile_type_v_o, pos_v_o, fetch_next_o, empty_o, lock_o, game_over_o;
  state_e     dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  tile_move_controller dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .cmd_left_i(cmd_left_i), .cmd_right_i(cmd_right_i),
    .cmd_rotate_i(cmd_rotate_i), .cmd_down_i(cmd_down_i),
    .tick_i(tick_i), .restart_i(restart_i), .ready_i(ready_i),
    .pos_i(pos_i), .type_i(type_i), .angle_i(angle_i),
    .next_type_i(next_type_i), .next_angle_i(next_angle_i),
    .move_avail_i(move_avail_i),
    .tile_type_o(tile_type_o), .tile_angle_o(tile_angle_o),
    .tile_type_v_o(tile_type_v_o), .new_pos_o(new_pos_o), .pos_v_o(pos_v_o),
    .fetch_next_o(fetch_next_o), .empty_o(empty_o), .lock_o(lock_o),
    .lock_ack_i(lock_ack_i), .game_over_o(game_over_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic to_play();
    repeat (4) cyc();
  endtask

  function automatic point_t pt(input logic [3:0] x, input logic [4:0] y);
    point_t p;
    p.x = x;
    p.y = y;
    return p;
  endfunction

  initial begin
    reset_ni = 1'b0;
    {cmd_left_i, cmd_right_i, cmd_rotate_i, cmd_down_i} = 4'b0000;
    tick_i = 1'b0; restart_i = 1'b0; lock_ack_i = 1'b0;
    ready_i = 1'b1;
    next_type_i = TILE_S; next_angle_i = 2'd2;
    type_i = TILE_T; angle_i = 2'd0;
    pos_i = pt(4'd3, 5'd5);
    move_avail_i = 4'b0000;

    // Reset: outputs low even though ready_i is high
    #3;
    chk("rst_type_v", tile_type_v_o, 0);
    chk("rst_pos_v", pos_v_o, 0);
    chk("rst_fetch", fetch_next_o, 0);
    chk("rst_empty", empty_o, 0);
    chk("rst_lock", lock_o, 0);
    chk("rst_over", game_over_o, 0);
    chk("rst_state", dbg_state_o, sSPAWN);

    // Spawn right after release
    #9 reset_ni = 1'b1;
    #1;
    chk("spawn_type_v", tile_type_v_o, 1);
    chk("spawn_type", tile_type_o, 3);
    chk("spawn_angle", tile_angle_o, 2);
    chk("spawn_pos_v", pos_v_o, 1);
    chk("spawn_pos", new_pos_o, pt(4'd3, 5'd0));

    cyc();
    ready_i = 1'b0;
    #1;
    chk("wspawn_state", dbg_state_o, sWAIT_SPAWN);
    chk("wspawn_pos_v", pos_v_o, 0);
    chk("wspawn_fetch", fetch_next_o, 0);
    cyc();
    ready_i = 1'b1;
    cyc();
    #1 chk("fetch_on", fetch_next_o, 1);
    cyc();
    ready_i = 1'b0;
    #1;
    chk("fetch_off", fetch_next_o, 0);
    chk("wait_state", dbg_state_o, sWAIT);
    cyc();
    ready_i = 1'b1;
    cyc();
    #1;
    chk("play_state", dbg_state_o, sPLAY);
    chk("play_idle", pos_v_o, 0);

    // Legal left
    move_avail_i = 4'b0001;
    cmd_left_i = 1'b1; cyc(); cmd_left_i = 1'b0;
    #1;
    chk("left_pos_v", pos_v_o, 1);
    chk("left_pos", new_pos_o, pt(4'd2, 5'd5));
    chk("left_type_v", tile_type_v_o, 0);
    cyc();
    #1 chk("left_wait", dbg_state_o, sWAIT);
    cyc();

    // Legal left from x=0 wraps
    pos_i = pt(4'd0, 5'd5);
    cmd_left_i = 1'b1; cyc(); cmd_left_i = 1'b0;
    #1 chk("wrap_pos", new_pos_o, pt(4'd15, 5'd5));
    cyc(); cyc();

    // Blocked left: no strobe, bit dropped
    pos_i = pt(4'd3, 5'd5);
    move_avail_i = 4'b0000;
    cmd_left_i = 1'b1; cyc(); cmd_left_i = 1'b0;
    #1 chk("blk_pos_v", pos_v_o, 0);
    cyc();
    #1 chk("blk_state", dbg_state_o, sPLAY);
    move_avail_i = 4'b0001;
    #1 chk("blk_dropped", pos_v_o, 0);

    // Rotate beats right; both arrive while the store is busy
    ready_i = 1'b0;
    angle_i = 2'd3; type_i = TILE_Z; move_avail_i = 4'b1111;
    cmd_rotate_i = 1'b1; cmd_right_i = 1'b1;
    cyc();
    cmd_rotate_i = 1'b0; cmd_right_i = 1'b0;
    #1;
    chk("busy_type_v", tile_type_v_o, 0);
    chk("busy_pos_v", pos_v_o, 0);
    ready_i = 1'b1;
    #1;
    chk("rot_type_v", tile_type_v_o, 1);
    chk("rot_type", tile_type_o, 4);
    chk("rot_angle", tile_angle_o, 0);
    chk("rot_pos_v", pos_v_o, 0);
    cyc(); cyc();
    #1;
    chk("right_pos_v", pos_v_o, 1);
    chk("right_pos", new_pos_o, pt(4'd4, 5'd5));
    chk("right_type_v", tile_type_v_o, 0);
    cyc(); cyc();
    #1 chk("queue_empty", pos_v_o, 0);

    // Landing via gravity tick
    pos_i = pt(4'd4, 5'd12);
    move_avail_i = 4'b1011;
    tick_i = 1'b1; cyc(); tick_i = 1'b0;
    #1 chk("land_pos_v", pos_v_o, 0);
    cyc();
    #1 chk("lock_on", lock_o, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("lock_hold", lock_o, 1);
      chk("lock_no_empty", empty_o, 0);
    end
    lock_ack_i = 1'b1; cyc(); lock_ack_i = 1'b0;
    #1;
    chk("clear_lock", lock_o, 0);
    chk("clear_empty", empty_o, 1);
    cyc();
    #1;
    chk("respawn_empty", empty_o, 0);
    chk("respawn_pos_v", pos_v_o, 1);
    chk("respawn_pos", new_pos_o, pt(4'd3, 5'd0));
    chk("respawn_over", game_over_o, 0);
    to_play();

    // Top-out: blocked down at the spawn row
    pos_i = pt(4'd3, 5'd0);
    move_avail_i = 4'b0000;
    cmd_down_i = 1'b1; cyc(); cmd_down_i = 1'b0;
    cyc();
    #1 chk("top_lock", lock_o, 1);
    lock_ack_i = 1'b1; cyc(); lock_ack_i = 1'b0;
    cyc();
    #1;
    chk("over_flag", game_over_o, 1);
    chk("over_state", dbg_state_o, sOVER);
    chk("over_empty", empty_o, 0);
    move_avail_i = 4'b1111;
    cmd_left_i = 1'b1; cyc(); cmd_left_i = 1'b0;
    cyc();
    #1;
    chk("over_hold", dbg_state_o, sOVER);
    chk("over_pos_v", pos_v_o, 0);
    restart_i = 1'b1;
    #1 chk("restart_empty", empty_o, 1);
    cyc();
    restart_i = 1'b0;
    #1;
    chk("restart_state", dbg_state_o, sSPAWN);
    chk("restart_pos", new_pos_o, pt(4'd3, 5'd0));
    chk("restart_over", game_over_o, 0);
    to_play();
    #1 chk("over_cmd_ignored", pos_v_o, 0);

    // Asynchronous reset while locked
    pos_i = pt(4'd4, 5'd7);
    move_avail_i = 4'b1011;
    tick_i = 1'b1; cyc(); tick_i = 1'b0;
    cyc();
    #1 chk("arst_pre_lock", lock_o, 1);
    reset_ni = 1'b0;
    #1;
    chk("arst_lock", lock_o, 0);
    chk("arst_state", dbg_state_o, sSPAWN);
    chk("arst_pos_v", pos_v_o, 0);
    #3 reset_ni = 1'b1;
    #1;
    chk("arst_spawn_pos_v", pos_v_o, 1);
    chk("arst_spawn_type_v", tile_type_v_o, 1);
    chk("arst_spawn_pos", new_pos_o, pt(4'd3, 5'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
